// File: rtl/calendar_pkg.sv
// Shared time-of-day constants, field widths and the countdown state type.
// Both the calendar and the countdown timer import this package.
package calendar_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } cd_state_t;

  // True when every field of an H:M:S triple is a legal time value.
  function automatic logic hms_valid(input logic [HOUR_W-1:0] hh,
                                     input logic [MIN_W-1:0]  mm,
                                     input logic [SEC_W-1:0]  ss);
    return (hh <= HOUR_MAX) && (mm <= MIN_MAX) && (ss <= SEC_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer. The master side (software
// or front panel) drives the strobes and load value; the timer is the slave.
interface countdown_timer_if;
  import calendar_pkg::*;

  logic              load;
  logic [HOUR_W-1:0] load_h;
  logic [MIN_W-1:0]  load_m;
  logic [SEC_W-1:0]  load_s;
  logic              start;
  logic              pause;
  logic [HOUR_W-1:0] h;
  logic [MIN_W-1:0]  m;
  logic [SEC_W-1:0]  s;
  logic              running;
  logic              done;
  logic              load_err;

  modport master (
    output load, load_h, load_m, load_s, start, pause,
    input  h, m, s, running, done, load_err
  );

  modport slave (
    input  load, load_h, load_m, load_s, start, pause,
    output h, m, s, running, done, load_err
  );

endinterface

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-per-second tick. The count only
// advances while enabled, so a pause keeps the partial second intact.
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PW            = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [PW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == PW'(TICKS_PER_SEC - 1));
  // Tick is decoded from the registered count only; clr is handled by the owner.
  assign tick   = en && w_wrap;

  // Cycle counter: clear on request, advance while enabled, wrap at end of second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PW'(1);
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// H:M:S countdown timer. Holds the run/pause/expiry FSM, the seconds ->
// minutes -> hours borrow chain and validation of loaded values. All
// outputs are registered.
module countdown_timer
  import calendar_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PW            = 26
) (
  input  logic             clk,
  input  logic             rst,
  countdown_timer_if.slave bus
);

  cd_state_t         r_state;
  logic [HOUR_W-1:0] r_h;
  logic [MIN_W-1:0]  r_m;
  logic [SEC_W-1:0]  r_s;
  logic              r_running;
  logic              r_done;
  logic              r_load_err;

  logic              w_load_ok;
  logic              w_pause_eff;
  logic              w_start_eff;
  logic              w_zero;
  logic              w_last;
  logic              w_tick;
  logic              w_ps_en;
  logic              w_ps_clr;
  logic [HOUR_W-1:0] w_dec_h;
  logic [MIN_W-1:0]  w_dec_m;
  logic [SEC_W-1:0]  w_dec_s;

  // Strobe priority: any load (good or bad) masks pause and start; pause masks start.
  assign w_load_ok   = bus.load && hms_valid(bus.load_h, bus.load_m, bus.load_s);
  assign w_pause_eff = !bus.load && bus.pause;
  assign w_start_eff = !bus.load && !bus.pause && bus.start;

  assign w_zero = (r_h == 5'd0) && (r_m == 6'd0) && (r_s == 6'd0);
  assign w_last = (r_h == 5'd0) && (r_m == 6'd0) && (r_s == 6'd1);

  // A fresh start begins a whole second; a resume from PAUSED keeps the phase.
  assign w_ps_en  = (r_state == RUN);
  assign w_ps_clr = w_load_ok || (w_start_eff && (r_state == IDLE));

  sec_prescaler #(
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .PW            (PW)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (w_ps_en),
    .clr  (w_ps_clr),
    .tick (w_tick)
  );

  // Next count after one second: borrow from minutes, then hours, on underflow.
  always_comb begin
    w_dec_h = r_h;
    w_dec_m = r_m;
    w_dec_s = r_s;
    if (r_s != 6'd0) begin
      w_dec_s = r_s - 6'd1;
    end else begin
      w_dec_s = SEC_MAX;
      if (r_m != 6'd0) begin
        w_dec_m = r_m - 6'd1;
      end else begin
        w_dec_m = MIN_MAX;
        w_dec_h = r_h - 5'd1;
      end
    end
  end

  // Timer FSM with registered count, running flag and one-cycle pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_h        <= 5'd0;
      r_m        <= 6'd0;
      r_s        <= 6'd0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
      if (w_load_ok) begin
        // A good load overrides everything, including a same-cycle expiry.
        r_h       <= bus.load_h;
        r_m       <= bus.load_m;
        r_s       <= bus.load_s;
        r_state   <= IDLE;
        r_running <= 1'b0;
      end else begin
        if (bus.load) begin
          r_load_err <= 1'b1;
        end
        case (r_state)
          IDLE: begin
            if (w_start_eff) begin
              if (w_zero) begin
                r_state <= EXPIRED;
                r_done  <= 1'b1;
              end else begin
                r_state   <= RUN;
                r_running <= 1'b1;
              end
            end
          end
          RUN: begin
            if (w_tick && w_last) begin
              r_h       <= w_dec_h;
              r_m       <= w_dec_m;
              r_s       <= w_dec_s;
              r_state   <= EXPIRED;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              if (w_tick) begin
                r_h <= w_dec_h;
                r_m <= w_dec_m;
                r_s <= w_dec_s;
              end
              if (w_pause_eff) begin
                r_state   <= PAUSED;
                r_running <= 1'b0;
              end
            end
          end
          PAUSED: begin
            if (w_start_eff && !w_zero) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          EXPIRED: begin
            r_h <= 5'd0;
            r_m <= 6'd0;
            r_s <= 6'd0;
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.h        = r_h;
  assign bus.m        = r_m;
  assign bus.s        = r_s;
  assign bus.running  = r_running;
  assign bus.done     = r_done;
  assign bus.load_err = r_load_err;

endmodule
